// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives 0..2^N_IN-1 onto a combinational DUT and checks each
// sampled output against EXPECT. Define SWEEP_STOP_ON_FAIL_EN to end the sweep on the first mismatch.
module truth_table_sweeper #(
    parameter int unsigned          N_IN   = 4,
    parameter int unsigned          SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 16'h00AA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  dut_y,
    output logic [N_IN-1:0]       stim,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  aborted,
    output logic [N_IN:0]         err_count,
    output logic                  fail_valid,
    output logic [N_IN-1:0]       first_fail_idx,
    output logic [(1<<N_IN)-1:0]  result_vec
);

    localparam int unsigned    NV   = 1 << N_IN;
    localparam logic [N_IN-1:0] LAST = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic [N_IN-1:0]   idx_q;
    logic [N_IN-1:0]   stim_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              aborted_q;
    logic [N_IN:0]     err_count_q;
    logic [N_IN:0]     err_count_d;
    logic              fail_valid_q;
    logic [N_IN-1:0]   first_fail_idx_q;
    logic [NV-1:0]     result_vec_q;

    logic mismatch;
    logic finish;

    // Sample-edge helpers: the mismatch and post-sample error count decide pass on the final edge.
    always_comb begin
        mismatch    = (dut_y != EXPECT[idx_q]);
        err_count_d = err_count_q + (N_IN+1)'(mismatch);
`ifdef SWEEP_STOP_ON_FAIL_EN
        finish      = (idx_q == LAST) || mismatch;
`else
        finish      = (idx_q == LAST);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            idx_q            <= '0;
            stim_q           <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            aborted_q        <= 1'b0;
            err_count_q      <= '0;
            fail_valid_q     <= 1'b0;
            first_fail_idx_q <= '0;
            result_vec_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q          <= HOLD;
                        idx_q            <= '0;
                        stim_q           <= '0;
                        cnt_q            <= '0;
                        busy_q           <= 1'b1;
                        err_count_q      <= '0;
                        fail_valid_q     <= 1'b0;
                        first_fail_idx_q <= '0;
                        result_vec_q     <= '0;
                        pass_q           <= 1'b0;
                        aborted_q        <= 1'b0;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        stim_q    <= '0;
                        aborted_q <= 1'b1;
                        pass_q    <= 1'b0;
                    end else if (cnt_q < 4'(SETTLE)) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        result_vec_q[idx_q] <= dut_y;
                        err_count_q         <= err_count_d;
                        if (mismatch && !fail_valid_q) begin
                            first_fail_idx_q <= idx_q;
                            fail_valid_q     <= 1'b1;
                        end
                        if (finish) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            stim_q  <= '0;
                            pass_q  <= (err_count_d == '0);
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            stim_q <= idx_q + 1'b1;
                            cnt_q  <= '0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign stim           = stim_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign aborted        = aborted_q;
    assign err_count      = err_count_q;
    assign fail_valid     = fail_valid_q;
    assign first_fail_idx = first_fail_idx_q;
    assign result_vec     = result_vec_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench for truth_table_sweeper: the stimulus pushes hand-computed sweep results,
// a monitor pops them whenever busy falls (done or abort) and compares.
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dut_y;
    logic [3:0]  stim;
    logic        busy, done, pass, aborted, fail_valid;
    logic [4:0]  err_count;
    logic [3:0]  first_fail_idx;
    logic [15:0] result_vec;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    typedef enum int { M_GOLD, M_STUCK0, M_STUCK1 } mode_t;
    mode_t mode = M_GOLD;

    typedef struct {
        string       name;
        logic [15:0] rv;
        logic [4:0]  err;
        logic [3:0]  ffi;
        logic        fv;
        logic        pass;
        logic        aborted;
        logic        done;
        int          cycles;
    } exp_t;

    exp_t exp_q[$];

    truth_table_sweeper #(.N_IN(4), .SETTLE(1), .EXPECT(16'h00AA)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(dut_y),
        .stim(stim), .busy(busy), .done(done), .pass(pass), .aborted(aborted),
        .err_count(err_count), .fail_valid(fail_valid),
        .first_fail_idx(first_fail_idx), .result_vec(result_vec)
    );

    always #5 clk = ~clk;

    // Combinational block under test: y = !a & d with stim = {a,b,c,d}, or stuck-at faults.
    always_comb begin
        case (mode)
            M_STUCK0: dut_y = 1'b0;
            M_STUCK1: dut_y = 1'b1;
            default:  dut_y = !stim[3] & stim[0];
        endcase
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Monitor: counts busy cycles and compares the sweep outcome when busy drops.
    initial begin
        logic busy_prev;
        int   busy_cnt;
        logic chk_low;
        exp_t e;
        busy_prev = 1'b0;
        busy_cnt  = 0;
        chk_low   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_prev = 1'b0;
                busy_cnt  = 0;
                chk_low   = 1'b0;
            end else begin
                if (chk_low) begin
                    chk("done_one_cycle", {31'b0, done}, 32'd0);
                    chk_low = 1'b0;
                end
                if (busy) busy_cnt++;
                if (busy_prev && !busy) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_end: got sweep end, required none");
                    end else begin
                        e = exp_q.pop_front();
                        chk({e.name, ".cycles"},  busy_cnt, e.cycles);
                        chk({e.name, ".done"},    {31'b0, done}, {31'b0, e.done});
                        chk({e.name, ".aborted"}, {31'b0, aborted}, {31'b0, e.aborted});
                        chk({e.name, ".pass"},    {31'b0, pass}, {31'b0, e.pass});
                        chk({e.name, ".rv"},      {16'b0, result_vec}, {16'b0, e.rv});
                        chk({e.name, ".err"},     {27'b0, err_count}, {27'b0, e.err});
                        chk({e.name, ".fv"},      {31'b0, fail_valid}, {31'b0, e.fv});
                        chk({e.name, ".ffi"},     {28'b0, first_fail_idx}, {28'b0, e.ffi});
                        chk({e.name, ".stim"},    {28'b0, stim}, 32'd0);
                    end
                    busy_cnt = 0;
                    chk_low  = 1'b1;
                end
                busy_prev = busy;
            end
        end
    end

    task automatic start_pulse(input logic with_abort);
        start = 1'b1;
        abort = with_abort;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s.timeout: got %0d pending, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_stim(input string nm, input logic [3:0] v);
        int i;
        for (i = 0; i < 100 && stim != v; i++) @(negedge clk);
        if (stim != v) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s.wait_stim: got %0h, required %0h", nm, stim, v);
        end
    endtask

    task automatic push(input string nm, input logic [15:0] rv, input logic [4:0] err,
                        input logic [3:0] ffi, input logic fv, input logic ps,
                        input logic ab, input logic dn, input int cyc);
        exp_t e;
        e.name = nm; e.rv = rv; e.err = err; e.ffi = ffi; e.fv = fv;
        e.pass = ps; e.aborted = ab; e.done = dn; e.cycles = cyc;
        exp_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, ".stim"}, {28'b0, stim}, 32'd0);
        chk({nm, ".flags"}, {27'b0, busy, done, pass, aborted, fail_valid}, 32'd0);
        chk({nm, ".err"}, {27'b0, err_count}, 32'd0);
        chk({nm, ".ffi"}, {28'b0, first_fail_idx}, 32'd0);
        chk({nm, ".rv"}, {16'b0, result_vec}, 32'd0);
    endtask

    initial begin
        #3;
        chk_all_zero("reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // Golden sweep; abort alongside start is ignored in IDLE.
        mode = M_GOLD;
        push("golden", 16'h00AA, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32);
        start_pulse(1'b1);
        drain("golden");

        mode = M_STUCK0;
`ifdef SWEEP_STOP_ON_FAIL_EN
        push("stuck0", 16'h0000, 5'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4);
`else
        push("stuck0", 16'h0000, 5'd4, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32);
`endif
        start_pulse(1'b0);
        drain("stuck0");

        mode = M_STUCK1;
`ifdef SWEEP_STOP_ON_FAIL_EN
        push("stuck1", 16'h0001, 5'd1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
`else
        push("stuck1", 16'hFFFF, 5'd12, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32);
`endif
        start_pulse(1'b0);
        drain("stuck1");

        // Abort while stim = 5: indices 0..4 captured (bits 1 and 3 set).
        mode = M_GOLD;
        push("abort", 16'h000A, 5'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 11);
        start_pulse(1'b0);
        wait_stim("abort", 4'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        drain("abort");

        // Re-pulsed start mid-sweep is ignored.
        push("restart", 16'h00AA, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32);
        start_pulse(1'b0);
        repeat (7) @(negedge clk);
        start_pulse(1'b0);
        drain("restart");

        // Asynchronous reset mid-sweep at stim = 9, then a clean sweep.
        start_pulse(1'b0);
        wait_stim("rst", 4'd9);
        #2 rst_n = 1'b0;
        #1 chk_all_zero("midreset");
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        push("post_reset", 16'h00AA, 5'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32);
        start_pulse(1'b0);
        drain("post_reset");

        repeat (5) @(negedge clk);
        chk("idle_stable.rv", {16'b0, result_vec}, 32'h00AA);
        chk("idle_stable.pass", {31'b0, pass}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Self-checking sequencer for a small combinational logic block under test (DUT).
- On a start pulse it drives every input combination 0..2^N_IN-1 onto the DUT inputs in ascending order, waits a programmable settle time, and samples the DUT output.
- It compares each sample against an expected truth table and reports the captured table, the mismatch count, the first failing index and a pass flag.
- Sits beside the lab combinational blocks and replaces hand-written exhaustive stimulus.

Parameters:
- N_IN, 4, number of DUT inputs; the sweep covers 2^N_IN vectors.
- SETTLE, 1, extra cycles each vector is held before sampling (0..15 legal). Each vector is held SETTLE+1 cycles.
- EXPECT, 16'h00AA, expected output per index, width 2^N_IN, bit i = expected y for stim=i. The default encodes y = !a & d with stim = {a,b,c,d}.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep; sampled only in IDLE.
- abort  in  1  cancel a sweep in progress; sampled only in HOLD.
- dut_y  in  1  DUT output.
- stim  out  N_IN  DUT input vector; stim[N_IN-1] = MSB (a).
- busy  out  1  high while a sweep is in progress.
- done  out  1  one-cycle pulse when a sweep completes.
- pass  out  1  high when the last completed sweep had err_count == 0.
- aborted  out  1  high when the last sweep was aborted.
- err_count  out  N_IN+1  number of mismatches; saturation is impossible, max 2^N_IN.
- fail_valid  out  1  at least one mismatch recorded.
- first_fail_idx  out  N_IN  index of the first mismatch.
- result_vec  out  2^N_IN  captured dut_y per index.

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - All outputs 0: stim, busy, done, pass, aborted, err_count, fail_valid, first_fail_idx, result_vec, internal cnt/idx.
  - Reset mid-sweep abandons the sweep immediately. No done pulse.
- IDLE:
  - Edge with start=1: state becomes HOLD, idx=0, stim=0, cnt=0, busy=1.
  - The same edge clears err_count, fail_valid, first_fail_idx, result_vec, pass and aborted.
- HOLD, each edge:
  - abort=1 has priority over everything else in HOLD. State becomes IDLE, busy=0, stim=0, aborted=1, done stays 0, pass=0. Captured results so far are kept.
  - Else if cnt < SETTLE: cnt increments.
  - Else (sample edge):
    - result_vec[idx] = dut_y.
    - On mismatch (dut_y != EXPECT[idx]): err_count increments. If fail_valid=0, set first_fail_idx=idx and fail_valid=1.
    - If idx == 2^N_IN-1: state becomes DONE, busy=0, done=1, stim=0. pass = 1 only if err_count after this sample is 0.
    - Else: idx increments, stim = idx+1, cnt=0.
- DONE: lasts exactly one cycle, then IDLE with done=0. start during DONE is ignored.
- start while busy is ignored. start and abort both high in IDLE: start wins, because abort is not sampled in IDLE.
- Timing: stim changes only on the edge that leaves a sample, so dut_y is stable for SETTLE+1 cycles.
  - Sweep length = 2^N_IN*(SETTLE+1) cycles from the start edge to the edge that raises done.
  - Defaults: 32 cycles.
- Results remain stable in IDLE until the next start.

Optional Feature:
- Macro: SWEEP_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the sweep on that sample edge. State goes to DONE, done pulses, pass=0, err_count=1, and result_vec holds only the indices up to and including the failure.
- Undefined: the sweep always runs all 2^N_IN vectors, and mismatches are only counted.

Test Plan:
1. Golden DUT y = !stim[3] & stim[0], defaults, start pulse:
   - done exactly 32 cycles after the start edge; busy high for 32 cycles.
   - result_vec = 16'h00AA, err_count = 0, pass = 1, fail_valid = 0.
2. DUT stuck at 0:
   - result_vec = 16'h0000, err_count = 4, first_fail_idx = 1, fail_valid = 1, pass = 0.
3. abort raised while stim = 5:
   - Next edge: busy = 0, stim = 0, aborted = 1.
   - No done pulse; result_vec[4:0] holds the captured values.
4. start re-pulsed mid-sweep:
   - Ignored, and the sweep still finishes at cycle 32.
5. rst_n low mid-sweep (stim = 9):
   - All outputs 0 immediately, asynchronously; a new start then runs a clean sweep.
6. SWEEP_STOP_ON_FAIL_EN defined, DUT stuck at 1:
   - First sample at index 0 mismatches; done pulses 2 cycles after start.
   - err_count = 1, first_fail_idx = 0, result_vec = 16'h0001.
